// File: rtl/cpu_multicycle_pkg.sv
// Shared types and encodings for the multi-cycle RV ALU-subset core.
package cpu_multicycle_pkg;

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MUL,
    S_WB,
    S_HALT
  } state_e;

  localparam int unsigned NUM_REGS = 32;

  localparam logic [6:0] OP_R = 7'b0110011;
  localparam logic [6:0] OP_I = 7'b0010011;

  localparam logic [2:0] F3_ADD = 3'b000;
  localparam logic [2:0] F3_SLL = 3'b001;
  localparam logic [2:0] F3_XOR = 3'b100;
  localparam logic [2:0] F3_SR  = 3'b101;
  localparam logic [2:0] F3_AND = 3'b111;

  localparam logic [6:0] F7_BASE   = 7'b0000000;
  localparam logic [6:0] F7_ALT    = 7'b0100000;
  localparam logic [6:0] F7_MULDIV = 7'b0000001;

  typedef enum logic [2:0] {
    ALU_ADD,
    ALU_SUB,
    ALU_AND,
    ALU_XOR,
    ALU_SLL,
    ALU_SRA,
    ALU_MUL
  } alu_op_e;

endpackage

// File: rtl/cpu_multicycle_regfile.sv
// 32-entry register file: two asynchronous read ports, one write port, x0 hardwired to zero.
module cpu_regfile
  import cpu_multicycle_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_we,
  input  logic [4:0]      i_waddr,
  input  logic [XLEN-1:0] i_wdata,
  input  logic [4:0]      i_raddr1,
  output logic [XLEN-1:0] o_rdata1,
  input  logic [4:0]      i_raddr2,
  output logic [XLEN-1:0] o_rdata2
);

  logic [XLEN-1:0] r_regs [NUM_REGS];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        r_regs[i] <= '0;
      end
    end else if (i_we && (i_waddr != '0)) begin
      r_regs[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata1 = (i_raddr1 == '0) ? '0 : r_regs[i_raddr1];
  assign o_rdata2 = (i_raddr2 == '0) ? '0 : r_regs[i_raddr2];

endmodule

// File: rtl/cpu_multicycle.sv
// Multi-cycle core for add/sub/and/xor/sll/mul/addi/srai with a req/valid fetch port
// and a retire trace port; mul uses an XLEN-cycle shift-add iteration.
module cpu_multicycle
  import cpu_multicycle_pkg::*;
#(
  parameter int unsigned     XLEN     = 32,
  parameter logic [XLEN-1:0] PC_RESET = '0,
  parameter bit              MUL_EN   = 1'b1
) (
  input  logic            clk_i,
  input  logic            rst_i,
  output logic            imem_req_o,
  output logic [XLEN-1:0] imem_addr_o,
  input  logic            imem_valid_i,
  input  logic [31:0]     imem_rdata_i,
  output logic            retire_o,
  output logic [XLEN-1:0] retire_pc_o,
  output logic [4:0]      retire_rd_o,
  output logic [XLEN-1:0] retire_data_o,
  output logic            halted_o
);

  localparam int unsigned SHW = $clog2(XLEN);

  state_e          r_state, w_state_nxt;
  logic            r_active;
  logic [XLEN-1:0] r_pc;
  logic [31:0]     r_ir;
  logic [XLEN-1:0] r_a, r_b, r_imm, r_res;
  alu_op_e         r_op, w_op;
  logic            r_use_imm, w_use_imm;
  logic            w_illegal;
  logic [SHW-1:0]  r_cnt;

  logic            w_fetch_ok;
  logic            w_we;
  logic [6:0]      w_opcode, w_funct7;
  logic [2:0]      w_funct3;
  logic [4:0]      w_rd;
  logic [XLEN-1:0] w_rs1_data, w_rs2_data, w_imm, w_opb, w_alu;

  assign w_opcode = r_ir[6:0];
  assign w_rd     = r_ir[11:7];
  assign w_funct3 = r_ir[14:12];
  assign w_funct7 = r_ir[31:25];
  assign w_imm    = {{(XLEN-12){r_ir[31]}}, r_ir[31:20]};

  cpu_regfile #(.XLEN(XLEN)) u_regfile (
    .i_clk    (clk_i),
    .i_rst_n  (rst_i),
    .i_we     (w_we),
    .i_waddr  (w_rd),
    .i_wdata  (r_res),
    .i_raddr1 (r_ir[19:15]),
    .o_rdata1 (w_rs1_data),
    .i_raddr2 (r_ir[24:20]),
    .o_rdata2 (w_rs2_data)
  );

  // r_active holds the request low until the first edge after reset release
  assign imem_req_o  = (r_state == S_FETCH) && r_active;
  assign imem_addr_o = r_pc;
  assign w_fetch_ok  = imem_req_o && imem_valid_i;
  assign w_we        = (r_state == S_WB);

  always_comb begin
    w_op      = ALU_ADD;
    w_use_imm = 1'b0;
    w_illegal = 1'b0;
    case (w_opcode)
      OP_R: begin
        if (w_funct7 == F7_BASE) begin
          case (w_funct3)
            F3_ADD:  w_op = ALU_ADD;
            F3_SLL:  w_op = ALU_SLL;
            F3_XOR:  w_op = ALU_XOR;
            F3_AND:  w_op = ALU_AND;
            default: w_illegal = 1'b1;
          endcase
        end else if ((w_funct7 == F7_ALT) && (w_funct3 == F3_ADD)) begin
          w_op = ALU_SUB;
        end else if (MUL_EN && (w_funct7 == F7_MULDIV) && (w_funct3 == F3_ADD)) begin
          w_op = ALU_MUL;
        end else begin
          w_illegal = 1'b1;
        end
      end
      OP_I: begin
        w_use_imm = 1'b1;
        if (w_funct3 == F3_ADD) begin
          w_op = ALU_ADD;
        end else if ((w_funct3 == F3_SR) && r_ir[30]) begin
          w_op = ALU_SRA;
        end else begin
          w_illegal = 1'b1;
        end
      end
      default: w_illegal = 1'b1;
    endcase
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_FETCH:  if (w_fetch_ok) w_state_nxt = S_DECODE;
      S_DECODE: begin
        if (w_illegal)            w_state_nxt = S_HALT;
        else if (w_op == ALU_MUL) w_state_nxt = S_MUL;
        else                      w_state_nxt = S_EXEC;
      end
      S_EXEC:   w_state_nxt = S_WB;
      S_MUL:    if (r_cnt == SHW'(XLEN - 1)) w_state_nxt = S_WB;
      S_WB:     w_state_nxt = S_FETCH;
      S_HALT:   w_state_nxt = S_HALT;
      default:  w_state_nxt = S_FETCH;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state  <= S_FETCH;
      r_active <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_active <= 1'b1;
    end
  end

  assign w_opb = r_use_imm ? r_imm : r_b;

  always_comb begin
    w_alu = r_a + w_opb;
    case (r_op)
      ALU_SUB: w_alu = r_a - w_opb;
      ALU_AND: w_alu = r_a & w_opb;
      ALU_XOR: w_alu = r_a ^ w_opb;
      ALU_SLL: w_alu = r_a << w_opb[SHW-1:0];
      ALU_SRA: w_alu = $signed(r_a) >>> w_opb[SHW-1:0];
      default: w_alu = r_a + w_opb;
    endcase
  end

  // In MUL, r_a is the shifting multiplicand and r_b the consumed multiplier
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_pc      <= PC_RESET;
      r_ir      <= '0;
      r_a       <= '0;
      r_b       <= '0;
      r_imm     <= '0;
      r_res     <= '0;
      r_op      <= ALU_ADD;
      r_use_imm <= 1'b0;
      r_cnt     <= '0;
    end else begin
      case (r_state)
        S_FETCH: if (w_fetch_ok) r_ir <= imem_rdata_i;
        S_DECODE: begin
          r_a       <= w_rs1_data;
          r_b       <= w_rs2_data;
          r_imm     <= w_imm;
          r_op      <= w_op;
          r_use_imm <= w_use_imm;
          r_res     <= '0;
          r_cnt     <= '0;
        end
        S_EXEC: r_res <= w_alu;
        S_MUL: begin
          if (r_b[0]) r_res <= r_res + r_a;
          r_a   <= r_a << 1;
          r_b   <= r_b >> 1;
          r_cnt <= r_cnt + SHW'(1);
        end
        S_WB: r_pc <= r_pc + XLEN'(4);
        default: ;
      endcase
    end
  end

  assign retire_o      = (r_state == S_WB);
  assign retire_pc_o   = retire_o ? r_pc : '0;
  assign retire_rd_o   = retire_o ? w_rd : '0;
  assign retire_data_o = (retire_o && (w_rd != '0)) ? r_res : '0;
  assign halted_o      = (r_state == S_HALT);

endmodule

// File: tb/tb_cpu_multicycle.sv
// Directed bench for cpu_multicycle: retire trace checked against a scoreboard of expected results.
module tb_cpu_multicycle;

  localparam int unsigned XLEN = 32;
  localparam logic [31:0] PCR  = 32'h0000_0100;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req, imem_valid;
  logic [31:0] imem_addr, imem_rdata;
  logic        retire;
  logic [31:0] retire_pc, retire_data;
  logic [4:0]  retire_rd;
  logic        halted;

  logic        nm_req, nm_valid, nm_retire, nm_halted;
  logic [31:0] nm_addr, nm_rdata, nm_retire_pc, nm_retire_data;
  logic [4:0]  nm_retire_rd;

  always #5 clk = ~clk;

  cpu_multicycle #(.XLEN(XLEN), .PC_RESET(PCR), .MUL_EN(1'b1)) u_dut (
    .clk_i(clk), .rst_i(rst_n),
    .imem_req_o(imem_req), .imem_addr_o(imem_addr),
    .imem_valid_i(imem_valid), .imem_rdata_i(imem_rdata),
    .retire_o(retire), .retire_pc_o(retire_pc), .retire_rd_o(retire_rd),
    .retire_data_o(retire_data), .halted_o(halted)
  );

  cpu_multicycle #(.XLEN(XLEN), .PC_RESET(PCR), .MUL_EN(1'b0)) u_dut_nomul (
    .clk_i(clk), .rst_i(rst_n),
    .imem_req_o(nm_req), .imem_addr_o(nm_addr),
    .imem_valid_i(nm_valid), .imem_rdata_i(nm_rdata),
    .retire_o(nm_retire), .retire_pc_o(nm_retire_pc), .retire_rd_o(nm_retire_rd),
    .retire_data_o(nm_retire_data), .halted_o(nm_halted)
  );

  typedef struct packed {
    logic [31:0] pc;
    logic [4:0]  rd;
    logic [31:0] data;
  } exp_t;

  exp_t        sb[$];
  int unsigned n_assert = 0;
  int unsigned n_fail   = 0;
  int unsigned cyc      = 0;
  int unsigned last_ret = 0;
  logic [31:0] exp_pc;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_req();
    int unsigned t = 0;
    while (!imem_req && t < 100) begin
      @(negedge clk);
      t++;
    end
    check("fetch_req", imem_req, 1);
    check("fetch_addr", imem_addr, exp_pc);
  endtask

  // Fetch one instruction (optionally stalled), then check its retire against the scoreboard.
  task automatic step(input logic [31:0] instr, input int unsigned stall,
                      input logic [4:0] rd, input logic [31:0] data, input int unsigned gap);
    int unsigned t = 0;
    exp_t e;
    wait_req();
    for (int unsigned i = 0; i < stall; i++) begin
      @(negedge clk);
      check("stall_req", imem_req, 1);
      check("stall_addr", imem_addr, exp_pc);
    end
    imem_valid = 1'b1;
    imem_rdata = instr;
    sb.push_back('{pc: exp_pc, rd: rd, data: data});
    @(negedge clk);
    imem_valid = 1'b0;
    imem_rdata = 32'hDEAD_BEEF;
    while (!retire && t < 200) begin
      @(negedge clk);
      t++;
    end
    check("retire_seen", retire, 1);
    if (retire && sb.size() != 0) begin
      e = sb.pop_front();
      check("retire_pc", retire_pc, e.pc);
      check("retire_rd", retire_rd, e.rd);
      check("retire_data", retire_data, e.data);
      if (gap != 0) check("retire_gap", cyc - last_ret, gap);
      last_ret = cyc;
    end
    @(negedge clk);
    check("retire_single", retire, 0);
    exp_pc = exp_pc + 32'd4;
  endtask

  task automatic do_reset();
    #2 rst_n = 1'b0;
    #1;
    check("rst_req", imem_req, 0);
    check("rst_addr", imem_addr, PCR);
    check("rst_retire", retire, 0);
    check("rst_retire_pc", retire_pc, 0);
    check("rst_retire_rd", retire_rd, 0);
    check("rst_retire_data", retire_data, 0);
    check("rst_halted", halted, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    check("req_at_release", imem_req, 0);
    @(negedge clk);
    check("req_after_release", imem_req, 1);
    exp_pc = PCR;
    sb.delete();
  endtask

  initial begin
    logic bad;
    rst_n      = 1'b1;
    imem_valid = 1'b0;
    imem_rdata = '0;
    nm_valid   = 1'b0;
    nm_rdata   = '0;
    exp_pc     = PCR;
    @(negedge clk);
    do_reset();

    // MUL_EN=0 instance: mul is illegal
    check("nomul_req", nm_req, 1);
    nm_valid = 1'b1;
    nm_rdata = 32'h0220_8233;
    @(negedge clk);
    nm_valid = 1'b0;
    @(negedge clk);
    check("nomul_halted", nm_halted, 1);
    check("nomul_req_low", nm_req, 0);
    check("nomul_no_retire", nm_retire, 0);

    step(32'h0050_0093, 0, 5'd1, 32'd5, 0);           // addi x1,x0,5
    step(32'h0010_8133, 0, 5'd2, 32'd10, 4);          // add  x2,x1,x1
    step(32'h4011_01B3, 0, 5'd3, 32'd5, 4);           // sub  x3,x2,x1
    step(32'h0220_8233, 0, 5'd4, 32'd50, 35);         // mul  x4,x1,x2
    step(32'hFFF0_0313, 0, 5'd6, 32'hFFFF_FFFF, 4);   // addi x6,x0,-1
    step(32'h4043_5393, 0, 5'd7, 32'hFFFF_FFFF, 4);   // srai x7,x6,4
    step(32'h01F0_0413, 0, 5'd8, 32'd31, 4);          // addi x8,x0,31
    step(32'h0080_94B3, 0, 5'd9, 32'h8000_0000, 4);   // sll  x9,x1,x8
    step(32'h0031_4533, 3, 5'd10, 32'd15, 7);         // xor  x10,x2,x3 (3 stall cycles)
    step(32'h0061_75B3, 0, 5'd11, 32'd10, 4);         // and  x11,x2,x6
    step(32'h0010_8033, 0, 5'd0, 32'd0, 4);           // add  x0,x1,x1
    step(32'h0013_0633, 0, 5'd12, 32'd4, 4);          // add  x12,x6,x1 (wraps)

    // Illegal opcode
    wait_req();
    imem_valid = 1'b1;
    imem_rdata = 32'h0000_007F;
    @(negedge clk);
    imem_valid = 1'b0;
    @(negedge clk);
    check("halted", halted, 1);
    check("halt_req", imem_req, 0);
    check("halt_retire", retire, 0);
    bad = 1'b0;
    for (int unsigned i = 0; i < 10; i++) begin
      @(negedge clk);
      if (retire || imem_req || !halted) bad = 1'b1;
    end
    check("halt_sticky", bad, 0);

    do_reset();
    step(32'h0050_0093, 0, 5'd1, 32'd5, 0);           // addi x1,x0,5
    step(32'h00A0_0113, 0, 5'd2, 32'd10, 4);          // addi x2,x0,10
    step(32'h0220_8233, 0, 5'd4, 32'd50, 35);         // mul  x4,x1,x2

    // Second mul, interrupted by reset mid-iteration
    wait_req();
    imem_valid = 1'b1;
    imem_rdata = 32'h0220_8233;
    sb.push_back('{pc: exp_pc, rd: 5'd4, data: 32'd50});
    @(negedge clk);
    imem_valid = 1'b0;
    for (int unsigned i = 0; i < 10; i++) @(negedge clk);
    check("mid_mul_no_retire", retire, 0);
    check("mid_mul_pending", sb.size(), 1);
    do_reset();
    step(32'h0042_02B3, 0, 5'd5, 32'd0, 0);           // add x5,x4,x4 -> x4 cleared

    check("sb_empty", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
